// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the one-cycle-latency instruction RAM: owns the PC,
// tracks the in-flight read and hands instructions to decode through a skid buffer.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MEM_SIZE = 1515,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_a,
  input  logic [31:0]       imem_rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              fetch_fault
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CMP_W   = ADDR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic              out_valid_q, out_valid_d;
  entry_t            out_q, out_d;
  logic              skid_valid_q, skid_valid_d;
  entry_t            skid_q, skid_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;

  logic              addr_legal;
  logic              accept;
  logic              issue;
  entry_t            arrival;

  // Next-state: drain/accept first, then place the arriving word, then decide issue.
  always_comb begin
    imem_a        = redirect_valid ? redirect_pc : pc_q;
    addr_legal    = {1'b0, imem_a} < CMP_W'(MEM_SIZE);
    accept        = out_valid_q && id_ready;
    arrival.instr = imem_rd;
    arrival.pc    = inflight_pc_q;

    out_valid_d   = out_valid_q;
    out_d         = out_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    issue         = 1'b0;

    if (accept) begin
      out_valid_d = skid_valid_q;
      if (skid_valid_q) begin
        out_d = skid_q;
      end
      skid_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (inflight_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_d       = arrival;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = arrival;
      end
    end

    // A pending fault blocks fetch unless this cycle's redirect clears it.
    issue   = addr_legal && (redirect_valid || !fault_q) && !skid_valid_d;
    fault_d = redirect_valid ? !addr_legal : (fault_q || !addr_legal);

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = imem_a;
      pc_d          = imem_a + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_q         <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      pc_q          <= ADDR_W'(RESET_PC);
      fault_q       <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_q         <= out_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
    end
  end

  assign id_valid    = out_valid_q;
  assign id_instr    = out_q.instr;
  assign id_pc       = out_q.pc;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: queue-level fetch model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_imem_fetch_ctrl;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned MEM_SIZE = 1515;
  localparam int unsigned RESET_PC = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] imem_a;
  logic [31:0]       imem_rd;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              fetch_fault;

  imem_fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .MEM_SIZE(MEM_SIZE),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_a        (imem_a),
    .imem_rd       (imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction RAM: word i holds i + 0x100, one-cycle read latency.
  logic [31:0] ram [0:65535];
  initial for (int i = 0; i < 65536; i++) ram[i] = 32'(i + 'h100);
  always @(posedge clk) imem_rd <= ram[imem_a];

  int n_pass  = 0;
  int n_total = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: buffered instructions as a queue of PCs, one optional read in flight.
  int m_buf[$];
  int m_inflight = -1;
  int m_pc = 0;
  bit m_fault = 0;
  bit m_overflow = 0;

  always @(posedge clk) begin
    int addr;
    bit legal;
    bit issue;
    if (rst) begin
      m_buf.delete();
      m_inflight = -1;
      m_pc       = RESET_PC;
      m_fault    = 0;
    end else begin
      addr = redirect_valid ? int'(redirect_pc) : m_pc;
      if (m_buf.size() > 0 && id_ready) void'(m_buf.pop_front());
      if (redirect_valid) m_buf.delete();
      else if (m_inflight >= 0) m_buf.push_back(m_inflight);
      if (m_buf.size() > 2) m_overflow = 1;
      legal   = addr < int'(MEM_SIZE);
      issue   = legal && (redirect_valid || !m_fault) && (m_buf.size() < 2);
      m_fault = redirect_valid ? !legal : (m_fault || !legal);
      if (issue) begin
        m_inflight = addr;
        m_pc       = (addr + 1) % 65536;
      end else begin
        m_inflight = -1;
      end
    end
  end

  int dut_log[$];
  always @(posedge clk) if (started && !rst && id_valid && id_ready) dut_log.push_back(int'(id_pc));

  always @(negedge clk) begin
    if (started) begin
      chk("id_valid", 32'(id_valid), 32'(m_buf.size() > 0));
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      if (m_buf.size() > 0) begin
        chk("id_pc", 32'(id_pc), 32'(m_buf[0]));
        chk("id_instr", id_instr, 32'(m_buf[0] + 'h100));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int pc);
    chk({name, "_valid"}, 32'(id_valid), 32'd1);
    chk({name, "_pc"}, 32'(id_pc), 32'(pc));
    chk({name, "_instr"}, id_instr, 32'(pc + 'h100));
  endtask

  initial begin
    int idx5;
    bit seen6;
    rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    started = 1;
    repeat (2) tick();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", 32'(id_pc), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // Startup latency and streaming.
    rst = 1'b0;
    tick(); chk("lat_valid0", 32'(id_valid), 32'd0);
    tick(); expect_out("first", 0);
    for (int k = 1; k <= 3; k++) begin tick(); expect_out("stream", k); end

    // Backpressure: pc 3 held for the whole stall.
    id_ready = 1'b0;
    repeat (5) begin tick(); expect_out("stall_hold", 3); end
    id_ready = 1'b1;
    tick(); expect_out("resume4", 4);
    tick(); expect_out("resume5", 5);

    // Redirect coincident with accept of pc 5.
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick(); redirect_valid = 1'b0;
    chk("redir_acc_valid0", 32'(id_valid), 32'd0);
    tick(); expect_out("redir_acc_tgt", 'h40);
    tick(); expect_out("redir_acc_next", 'h41);

    // Redirect while stalled with the skid full.
    id_ready = 1'b0;
    tick(); tick(); expect_out("stall_skid", 'h41);
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    tick(); redirect_valid = 1'b0;
    chk("redir_stall_valid0", 32'(id_valid), 32'd0);
    tick(); expect_out("redir_stall_tgt", 'h20);
    id_ready = 1'b1;
    tick(); expect_out("redir_stall_n1", 'h21);
    tick(); expect_out("redir_stall_n2", 'h22);

    idx5 = -1; seen6 = 0;
    foreach (dut_log[i]) begin
      if (dut_log[i] == 5) idx5 = i;
      if (dut_log[i] == 6) seen6 = 1;
    end
    chk("pc5_consumed", 32'(idx5 >= 0), 32'd1);
    if (idx5 >= 0 && idx5 + 1 < dut_log.size())
      chk("after_pc5", 32'(dut_log[idx5 + 1]), 32'h40);
    else
      chk("after_pc5_present", 32'd0, 32'd1);
    chk("pc6_never", 32'(seen6), 32'd0);
    chk("no_overflow", 32'(m_overflow), 32'd0);

    // Reset mid-stream with decode stalled.
    id_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_instr", id_instr, 32'd0);
    chk("mid_rst_pc", 32'(id_pc), 32'd0);
    chk("mid_rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;
    tick(); chk("mid_rst_lat", 32'(id_valid), 32'd0);
    tick(); expect_out("mid_rst_first", 0);
    id_ready = 1'b1;
    tick(); expect_out("mid_rst_second", 1);

    // Run off the end of the populated range.
    redirect_valid = 1'b1; redirect_pc = 16'(1510);
    tick(); redirect_valid = 1'b0;
    chk("end_valid0", 32'(id_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); expect_out("end_stream", 1510 + k);
      chk("end_nofault", 32'(fetch_fault), 32'd0);
    end
    tick(); expect_out("end_last", 1514);
    chk("end_fault", 32'(fetch_fault), 32'd1);
    tick();
    chk("end_drained", 32'(id_valid), 32'd0);
    repeat (3) tick();
    chk("end_halted_valid", 32'(id_valid), 32'd0);
    chk("end_halted_fault", 32'(fetch_fault), 32'd1);

    // Redirect out of the fault, then to an illegal target.
    redirect_valid = 1'b1; redirect_pc = 16'd0;
    tick(); redirect_valid = 1'b0;
    chk("clr_fault", 32'(fetch_fault), 32'd0);
    chk("clr_valid0", 32'(id_valid), 32'd0);
    tick(); expect_out("clr_first", 0);
    redirect_valid = 1'b1; redirect_pc = 16'd2000;
    tick(); redirect_valid = 1'b0;
    chk("bad_tgt_fault", 32'(fetch_fault), 32'd1);
    chk("bad_tgt_valid", 32'(id_valid), 32'd0);
    repeat (3) tick();
    chk("bad_tgt_hold_valid", 32'(id_valid), 32'd0);
    chk("bad_tgt_hold_fault", 32'(fetch_fault), 32'd1);
    chk("final_no_overflow", 32'(m_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
